// File: rtl/uc_secuenciador_pkg.sv
// Shared types for the multicycle control sequencer:
// state encoding, opcode classes and control-word layout.
package uc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   localparam logic [3:0] OPC_LOAD = 4'b1000;
   localparam logic [3:0] OPC_JMP  = 4'b1001;
   localparam logic [3:0] OPC_JZ   = 4'b1010;
   localparam logic [3:0] OPC_JNZ  = 4'b1011;
   localparam logic [3:0] OPC_HALT = 4'b1111;

   // Datapath-facing part of the control word, driven only in EXEC.
   typedef struct packed {
      logic       pc_we;
      logic       s_inc;
      logic       s_inm;
      logic       we3;
      logic [2:0] op;
   } exe_t;

   typedef struct packed {
      exe_t exe;
      logic illegal;
      logic halt;
   } ctrl_t;

   localparam exe_t EXE_NONE = '0;

   function automatic logic is_alu(input logic [3:0] cls);
      return !cls[3];
   endfunction

endpackage

// File: rtl/uc_secuenciador_if.sv
// Program-memory fetch handshake between the sequencer
// and the instruction memory / instruction register.
interface uc_secuenciador_if;
   logic       mem_req;
   logic       mem_rdy;
   logic [5:0] opcode;

   modport master (
      output mem_req,
      input  mem_rdy,
      input  opcode
   );

   modport slave (
      input  mem_req,
      output mem_rdy,
      output opcode
   );
endinterface

// File: rtl/uc_secuenciador_decode.sv
// Combinational opcode classifier: opcode + sampled z
// to the control word latched by the sequencer.
module uc_decode
   import uc_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic       z,
   output ctrl_t      ctrl
);

   logic [3:0] cls;
   logic       unused_hi;

   assign cls       = opcode[3:0];
   assign unused_hi = ^opcode[5:4];

   always_comb begin
      ctrl = '0;
      unique case (1'b1)
         is_alu(cls): begin
            ctrl.exe.pc_we = 1'b1;
            ctrl.exe.s_inc = 1'b1;
            ctrl.exe.we3   = 1'b1;
            ctrl.exe.op    = cls[2:0];
         end
         cls == OPC_LOAD: begin
            ctrl.exe.pc_we = 1'b1;
            ctrl.exe.s_inc = 1'b1;
            ctrl.exe.s_inm = 1'b1;
            ctrl.exe.we3   = 1'b1;
         end
         cls == OPC_JMP: begin
            ctrl.exe.pc_we = 1'b1;
         end
         cls == OPC_JZ: begin
            ctrl.exe.pc_we = 1'b1;
            ctrl.exe.s_inc = ~z;
         end
         cls == OPC_JNZ: begin
            ctrl.exe.pc_we = 1'b1;
            ctrl.exe.s_inc = z;
         end
         cls == OPC_HALT: begin
            ctrl.halt = 1'b1;
         end
         // 1100..1110: step over as a NOP and flag it
         default: begin
            ctrl.exe.pc_we = 1'b1;
            ctrl.exe.s_inc = 1'b1;
            ctrl.illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/uc_secuenciador.sv
// FETCH/DECODE/EXEC control sequencer for the accumulator
// datapath, with fetch watchdog and retired-instruction counter.
module uc_secuenciador
   import uc_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   uc_secuenciador_if.master mem,
   input  logic             z,
   output logic             ir_we,
   output logic             pc_we,
   output logic             s_inc,
   output logic             s_inm,
   output logic             we3,
   output logic [2:0]       op,
   output logic             fin,
   output logic             err,
   output logic             busy,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   state_t           state_q;
   logic [WD_W-1:0]  wd_q;
   logic [CNT_W-1:0] cnt_q;
   exe_t             ctrl_q;
   logic             mem_req_q;
   logic             fin_q;
   logic             err_q;
   logic             busy_q;
   ctrl_t            dec;

   uc_decode u_dec (
      .opcode (mem.opcode),
      .z      (z),
      .ctrl   (dec)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         wd_q      <= '0;
         cnt_q     <= '0;
         ctrl_q    <= EXE_NONE;
         mem_req_q <= 1'b0;
         fin_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q   <= S_FETCH;
                  mem_req_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_FETCH: begin
               // a late mem_rdy at the watchdog limit still wins
               if (mem.mem_rdy) begin
                  state_q   <= S_DECODE;
                  mem_req_q <= 1'b0;
                  wd_q      <= '0;
               end else if (wd_q == WD_MAX) begin
                  state_q   <= S_HALT;
                  mem_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  fin_q     <= 1'b1;
                  err_q     <= 1'b1;
                  wd_q      <= '0;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            S_DECODE: begin
               if (dec.halt) begin
                  state_q <= S_HALT;
                  busy_q  <= 1'b0;
                  fin_q   <= 1'b1;
               end else begin
                  state_q <= S_EXEC;
                  ctrl_q  <= dec.exe;
                  if (dec.illegal)
                     err_q <= 1'b1;
               end
            end
            S_EXEC: begin
               state_q   <= S_FETCH;
               ctrl_q    <= EXE_NONE;
               mem_req_q <= 1'b1;
               if (cnt_q != '1)
                  cnt_q <= cnt_q + CNT_W'(1);
            end
            S_HALT: begin
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign mem.mem_req = mem_req_q;
   assign ir_we       = mem_req_q & mem.mem_rdy;
   assign pc_we       = ctrl_q.pc_we;
   assign s_inc       = ctrl_q.s_inc;
   assign s_inm       = ctrl_q.s_inm;
   assign we3         = ctrl_q.we3;
   assign op          = ctrl_q.op;
   assign fin         = fin_q;
   assign err         = err_q;
   assign busy        = busy_q;
   assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_uc_secuenciador.sv
// Self-checking bench for uc_secuenciador: instruction vector
// table with a scoreboard plus hand-written corner sequences.
module tb_uc_secuenciador;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        start_s = 1'b0;
   logic        z = 1'b0;
   logic        ir_we, pc_we, s_inc, s_inm, we3;
   logic [2:0]  op;
   logic        fin, err, busy;
   logic [15:0] instr_cnt;
   logic        ir_we_s, pc_we_s, s_inc_s, s_inm_s, we3_s;
   logic [2:0]  op_s;
   logic        fin_s, err_s, busy_s;
   logic [1:0]  instr_cnt_s;

   uc_secuenciador_if m_if ();
   uc_secuenciador_if s_if ();

   uc_secuenciador #(.TIMEOUT(16), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mem       (m_if),
      .z         (z),
      .ir_we     (ir_we),
      .pc_we     (pc_we),
      .s_inc     (s_inc),
      .s_inm     (s_inm),
      .we3       (we3),
      .op        (op),
      .fin       (fin),
      .err       (err),
      .busy      (busy),
      .instr_cnt (instr_cnt)
   );

   uc_secuenciador #(.TIMEOUT(16), .CNT_W(2)) u_sat (
      .clk       (clk),
      .reset     (reset),
      .start     (start_s),
      .mem       (s_if),
      .z         (z),
      .ir_we     (ir_we_s),
      .pc_we     (pc_we_s),
      .s_inc     (s_inc_s),
      .s_inm     (s_inm_s),
      .we3       (we3_s),
      .op        (op_s),
      .fin       (fin_s),
      .err       (err_s),
      .busy      (busy_s),
      .instr_cnt (instr_cnt_s)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] opc;
      logic       zd;
      logic       ze;
      logic [7:0] exp;
   } vec_t;

   vec_t       vt [10];
   logic [7:0] sb [$];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = 1'b0;
      reset = 1'b0;
      #3;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic [7:0] e;
      int n;
      // {pc_we,s_inc,s_inm,we3}, op, err
      vt[0] = '{6'b000010, 1'b0, 1'b0, {4'b1101, 3'b010, 1'b0}};
      vt[1] = '{6'b110101, 1'b0, 1'b0, {4'b1101, 3'b101, 1'b0}};
      vt[2] = '{6'b001000, 1'b0, 1'b0, {4'b1111, 3'b000, 1'b0}};
      vt[3] = '{6'b001001, 1'b0, 1'b0, {4'b1000, 3'b000, 1'b0}};
      vt[4] = '{6'b001010, 1'b1, 1'b0, {4'b1000, 3'b000, 1'b0}};
      vt[5] = '{6'b001010, 1'b0, 1'b1, {4'b1100, 3'b000, 1'b0}};
      vt[6] = '{6'b001011, 1'b1, 1'b0, {4'b1100, 3'b000, 1'b0}};
      vt[7] = '{6'b001011, 1'b0, 1'b1, {4'b1000, 3'b000, 1'b0}};
      vt[8] = '{6'b001100, 1'b0, 1'b0, {4'b1100, 3'b000, 1'b1}};
      vt[9] = '{6'b111110, 1'b0, 1'b0, {4'b1100, 3'b000, 1'b1}};

      m_if.mem_rdy = 1'b0;
      m_if.opcode  = 6'b0;
      s_if.mem_rdy = 1'b1;
      s_if.opcode  = 6'b000001;

      reset = 1'b0;
      #7;
      chk("reset_outs",
          {m_if.mem_req, ir_we, pc_we, s_inc, s_inm, we3, op,
           fin, err, busy, instr_cnt}, 32'h0);
      do_reset();

      for (int i = 0; i < 10; i++) begin
         do_reset();
         m_if.opcode  = vt[i].opc;
         m_if.mem_rdy = 1'b1;
         z            = vt[i].zd;
         start        = 1'b1;
         sb.push_back(vt[i].exp);
         tick();
         start = 1'b0;
         chk($sformatf("fetch%0d", i), {m_if.mem_req, ir_we, busy}, 3'b111);
         tick();
         chk($sformatf("decode%0d", i), {m_if.mem_req, pc_we, we3}, 3'b000);
         tick();
         z = vt[i].ze;
         n = 0;
         while (!pc_we && n < 8) begin
            tick();
            n++;
         end
         if (!pc_we) begin
            chk($sformatf("exec_timeout%0d", i), 32'd0, 32'd1);
            void'(sb.pop_front());
         end else if (sb.size() == 0) begin
            chk($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk($sformatf("exec%0d", i),
                {pc_we, s_inc, s_inm, we3, op, err}, e);
            chk($sformatf("exec_cnt%0d", i), instr_cnt, 0);
         end
         tick();
         chk($sformatf("next%0d", i),
             {m_if.mem_req, pc_we, instr_cnt}, {2'b10, 16'd1});
      end

      // watchdog expiry
      do_reset();
      m_if.mem_rdy = 1'b0;
      m_if.opcode  = 6'b000010;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (m_if.mem_req && n < 40) begin
         n++;
         tick();
      end
      chk("wd_cycles", n, 16);
      chk("wd_halt", {fin, err, busy, m_if.mem_req}, 4'b1100);
      m_if.mem_rdy = 1'b1;
      start = 1'b1;
      repeat (3) tick();
      start = 1'b0;
      chk("halt_sticky",
          {fin, err, busy, m_if.mem_req, ir_we, pc_we, instr_cnt},
          {6'b110000, 16'd0});

      // mem_rdy arriving at the watchdog limit is a fetch
      do_reset();
      m_if.mem_rdy = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      m_if.mem_rdy = 1'b1;
      #1;
      chk("wd_edge_fetch", {m_if.mem_req, ir_we}, 2'b11);
      tick();
      chk("wd_edge_dec", {fin, err, busy}, 3'b001);
      tick();
      chk("wd_edge_exec", {pc_we, we3, op}, {2'b11, 3'b010});

      // halt opcode as first instruction
      do_reset();
      m_if.opcode = 6'b001111;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("halt_direct",
          {fin, err, busy, pc_we, we3, instr_cnt}, {5'b10000, 16'd0});

      // ALU then HALT: count stays at one
      do_reset();
      m_if.opcode = 6'b000011;
      start = 1'b1;
      tick();
      tick();
      tick();
      chk("alu_pre_halt", {pc_we, we3, op}, {2'b11, 3'b011});
      m_if.opcode = 6'b001111;
      tick();
      tick();
      chk("halt_dec", pc_we, 0);
      tick();
      chk("halt_after_alu",
          {fin, err, busy, pc_we, we3, instr_cnt}, {5'b10000, 16'd1});
      repeat (4) tick();
      start = 1'b0;
      chk("halt_hold", {fin, busy, m_if.mem_req, instr_cnt},
          {3'b100, 16'd1});

      // async reset in the middle of EXEC
      do_reset();
      m_if.opcode = 6'b001000;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      chk("pre_rst_exec", {pc_we, we3, s_inm}, 3'b111);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst",
          {m_if.mem_req, ir_we, pc_we, s_inc, s_inm, we3, op,
           fin, err, busy, instr_cnt}, 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk("post_rst_idle", {m_if.mem_req, busy, pc_we}, 3'b000);

      // saturating 2-bit counter
      start_s = 1'b1;
      tick();
      start_s = 1'b0;
      repeat (6) tick();
      chk("sat_cnt2", instr_cnt_s, 2);
      repeat (3) tick();
      chk("sat_cnt3", instr_cnt_s, 3);
      repeat (6) tick();
      chk("sat_hold", instr_cnt_s, 3);

      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uc_secuenciador.md
Name: uc_secuenciador

Overview:
- Multicycle control sequencer for the single-accumulator CPU datapath (PC, instruction register, register bank, ALU, zero flag).
- Replaces purely combinational control with a FETCH/DECODE/EXEC state machine.
- Handshakes with a program memory that can stall, and drives the same control lines as the existing decoder.
- Adds a fetch watchdog, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, consecutive FETCH cycles without mem_rdy before an error halt (≥2).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets).
- start  in  1  begin execution from IDLE.
- mem_rdy  in  1  program memory has valid instruction this cycle.
- opcode  in  6  instruction register opcode field, stable from DECODE onward.
- z  in  1  datapath zero flag from the previous ALU operation.
- mem_req  out  1  fetch request to program memory.
- ir_we  out  1  load instruction register.
- pc_we  out  1  PC update enable.
- s_inc  out  1  1 = PC+1, 0 = jump target.
- s_inm  out  1  1 = immediate to WD3, 0 = ALU result.
- we3  out  1  register bank write enable.
- op  out  3  ALU operation.
- fin  out  1  halted, sticky until reset.
- err  out  1  sticky: illegal opcode or fetch timeout.
- busy  out  1  state is not IDLE or HALT.
- instr_cnt  out  CNT_W  retired instructions, saturating.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, instr_cnt=0, watchdog=0, latched decision cleared.
- States and transitions:
  - IDLE: start=1 -> FETCH next cycle; otherwise stay.
  - FETCH: mem_req=1.
    - mem_rdy=1: ir_we=1 in the same cycle, watchdog cleared, -> DECODE.
    - mem_rdy=0: watchdog+1. When the watchdog reaches TIMEOUT-1 with mem_rdy still 0 -> HALT with err=1 and fin=1.
  - DECODE: one cycle. Classifies opcode and samples z into an internal register; the decision uses only this sampled z. -> EXEC, or -> HALT for the halt opcode.
  - EXEC: exactly one cycle of control pulses, then -> FETCH.
  - HALT: fin=1, busy=0, start ignored. Only reset exits.
- Opcode classes, bit3 and [3:0]; bits 5:4 are don't-care:
  - ALU (bit3=0): we3=1, s_inm=0, s_inc=1, pc_we=1, op=opcode[2:0].
  - LOAD 1000: we3=1, s_inm=1, s_inc=1, pc_we=1.
  - JMP 1001: pc_we=1, s_inc=0, we3=0.
  - JZ 1010: pc_we=1, s_inc = ~z_sampled, we3=0.
  - JNZ 1011: pc_we=1, s_inc = z_sampled, we3=0.
  - HALT 1111: no EXEC cycle. From DECODE directly to HALT; pc_we and we3 stay 0.
  - 1100, 1101, 1110 are illegal: treated as NOP (pc_we=1, s_inc=1, we3=0), err set sticky, execution continues.
- Output values by state:
  - Outside EXEC: pc_we=0, we3=0, s_inc=0, s_inm=0, op=000.
  - ir_we and mem_req are only ever 1 in FETCH.
- instr_cnt:
  - +1 at the end of every EXEC cycle, including illegal NOPs.
  - Saturates at all-ones; HALT does not count.
- Latency: minimum 3 cycles per instruction (FETCH with immediate rdy, DECODE, EXEC); each mem_rdy=0 cycle adds one.
- Simultaneous events:
  - start during FETCH, DECODE or EXEC is ignored.
  - A mem_rdy pulse in the same cycle as the watchdog limit counts as a fetch, not a timeout.
- Reset mid-instruction: immediate return to IDLE. No partial pc_we/we3 pulse survives an async assertion.

Decomposition:
- Package uc_pkg:
  - State encoding.
  - Opcode-class constants (OPC_LOAD=4'b1000, OPC_JMP=4'b1001, OPC_JZ=4'b1010, OPC_JNZ=4'b1011, OPC_HALT=4'b1111).
  - Control-word field layout.
- Sub-module uc_decode (combinational): opcode and sampled z -> control word {pc_we, s_inc, s_inm, we3, op, illegal, halt}. The sequencer registers the word in DECODE and drives it only in EXEC.

Test Plan:
- Reset, then start=1 with mem_rdy tied 1 and opcode=000010 -> mem_req/ir_we in cycle 1, EXEC pulse in cycle 3 with we3=1, op=010, s_inc=1, pc_we=1; instr_cnt=1.
- LOAD 001000 -> EXEC we3=1, s_inm=1, s_inc=1. JMP 001001 -> pc_we=1, s_inc=0, we3=0.
- JZ 001010 with z=1 at DECODE and z=0 at EXEC -> s_inc=0 (jump taken; sampled z wins). Same instruction with z=0 -> s_inc=1. Mirror both cases for JNZ 001011.
- mem_rdy held 0, TIMEOUT=16 -> HALT after 16 FETCH cycles with err=1, fin=1, busy=0; later mem_rdy and start have no effect.
- Opcode 001100 -> NOP pulse (pc_we=1, we3=0), err=1, next FETCH proceeds. Opcode 001111 -> fin=1 with no pc_we pulse, instr_cnt unchanged.
- reset=0 asserted mid-EXEC -> all outputs 0 immediately, state IDLE. CNT_W=2 with 5 instructions -> instr_cnt=3 (saturated).
